// File: rtl/dds_freq_meter.sv
// Frequency meter for a signed periodic sample stream. It counts samples across NPER rising
// zero crossings, then divides NPER*2^32 by that count to recover the DDS frequency word.
module dds_freq_meter #(
  parameter int DW        = 8,
  parameter int HYST      = 8,
  parameter int LOG2_NPER = 4,
  parameter int TMO       = 2**24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 din_valid,
  input  logic signed [DW-1:0] din,
  output logic        [31:0]   fword_est,
  output logic        [31:0]   sample_cnt,
  output logic signed [DW-1:0] amp_peak,
  output logic                 meas_valid,
  output logic                 timeout
);

  localparam int NPER = 2**LOG2_NPER;
  localparam logic signed [DW-1:0] NEG_HYST = DW'(-HYST);
  localparam logic [LOG2_NPER-1:0] PER_LAST = LOG2_NPER'(NPER - 1);
  localparam logic [31:0]          S_LAST   = 32'(TMO - 1);
  // Numerator is NPER*2^32; its bits above 31 form the starting remainder.
  localparam logic [31:0]          REM_INIT = 32'(NPER);

  typedef enum logic [2:0] {IDLE, COUNT, DIV_LOAD, DIV, DONE} state_t;

  state_t                 state;
  logic                   armed;
  logic                   rise;
  logic                   arm_hit;
  logic [31:0]            s_cnt;
  logic [LOG2_NPER-1:0]   per_cnt;
  logic [4:0]             bit_cnt;
  logic signed [DW-1:0]   peak;
  logic [31:0]            rem;
  logic [31:0]            quo;
  logic [32:0]            div_res;

  // One restoring-division step: returns {quotient bit, next remainder}.
  function automatic logic [32:0] div_step(input logic [31:0] r, input logic [31:0] dvs);
    logic [32:0] sh;
    sh = {r, 1'b0};
    if (sh >= {1'b0, dvs})
      div_step = {1'b1, 32'(sh - {1'b0, dvs})};
    else
      div_step = {1'b0, sh[31:0]};
  endfunction

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    smax = (a > b) ? a : b;
  endfunction

  assign arm_hit = din_valid && (din <= NEG_HYST);
  assign rise    = din_valid && armed && !din[DW-1];
  assign div_res = div_step(rem, s_cnt);

  // Crossing detector: keeps tracking even while the divider runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else if (!en) begin
      armed <= 1'b0;
    end else if (arm_hit) begin
      armed <= 1'b1;
    end else if (rise) begin
      armed <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      s_cnt      <= '0;
      per_cnt    <= '0;
      bit_cnt    <= '0;
      fword_est  <= '0;
      sample_cnt <= '0;
      amp_peak   <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      if (!en) begin
        state   <= IDLE;
        s_cnt   <= '0;
        per_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state   <= COUNT;
              s_cnt   <= '0;
              per_cnt <= '0;
            end
          end
          COUNT: begin
            if (din_valid) begin
              s_cnt <= s_cnt + 32'd1;
              if (rise && per_cnt == PER_LAST) begin
                state <= DIV_LOAD;
              end else begin
                if (rise) per_cnt <= per_cnt + 1'b1;
                if (s_cnt == S_LAST) begin
                  timeout <= 1'b1;
                  state   <= IDLE;
                end
              end
            end
          end
          DIV_LOAD: begin
            bit_cnt <= '0;
            state   <= DIV;
          end
          DIV: begin
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd31) state <= DONE;
          end
          DONE: begin
            fword_est  <= quo;
            sample_cnt <= s_cnt;
            amp_peak   <= peak;
            meas_valid <= 1'b1;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Window peak and divider registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (en && state == IDLE && rise)
      peak <= din;
    else if (en && state == COUNT && din_valid)
      peak <= smax(peak, din);

    if (state == DIV_LOAD) begin
      rem <= REM_INIT;
      quo <= '0;
    end else if (state == DIV) begin
      rem <= div_res[31:0];
      quo <= {quo[30:0], div_res[32]};
    end
  end

endmodule

// File: tb/tb_dds_freq_meter.sv
// Bench for dds_freq_meter: drives DDS-style sine streams from a table of scenarios, predicts
// every result/timeout pulse with a behavioural model and checks them from a scoreboard queue.
module tb_dds_freq_meter;

  localparam int DW        = 8;
  localparam int HYST      = 8;
  localparam int LOG2_NPER = 4;
  localparam int NPER      = 16;
  localparam int TMO       = 6000;
  localparam int DIV_LAT   = 34;
  localparam longint NUM   = longint'(1) << (32 + LOG2_NPER);

  logic                 clk;
  logic                 rst_n;
  logic                 en;
  logic                 din_valid;
  logic signed [DW-1:0] din;
  logic [31:0]          fword_est;
  logic [31:0]          sample_cnt;
  logic signed [DW-1:0] amp_peak;
  logic                 meas_valid;
  logic                 timeout;

  dds_freq_meter #(
    .DW(DW), .HYST(HYST), .LOG2_NPER(LOG2_NPER), .TMO(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din_valid(din_valid), .din(din),
    .fword_est(fword_est), .sample_cnt(sample_cnt), .amp_peak(amp_peak),
    .meas_valid(meas_valid), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [31:0] fw;
    int          noise;
    int          duty;
    int          nres;
    int          stol;
    longint      es;
    longint      efw;
    longint      fwtol;
    int          pk;
  } vec_t;

  typedef struct {
    int     cyc;
    int     s;
    longint fw;
    int     pk;
  } res_t;

  vec_t        vt [4];
  vec_t        cur;
  bit          cur_on = 1'b0;
  res_t        mq [$];
  int          tq [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          meas_cnt = 0;
  int          tmo_cnt = 0;
  int          cyc = 0;
  int          m_state = 0;
  bit          m_armed = 1'b0;
  int          m_s = 0;
  int          m_per = 0;
  int          m_peak = 0;
  int          m_busy = 0;
  int          last_s = 0;
  longint      last_fw = 0;
  int          last_pk = 0;
  logic [31:0] ph = '0;

  function automatic vec_t mk(input logic [31:0] fw, input int noise, input int duty,
                              input int nres, input int stol, input longint es,
                              input longint efw, input longint fwtol, input int pk);
    vec_t v;
    v.fw = fw; v.noise = noise; v.duty = duty; v.nres = nres; v.stol = stol;
    v.es = es; v.efw = efw; v.fwtol = fwtol; v.pk = pk;
    return v;
  endfunction

  function automatic int sine_of(input logic [31:0] p);
    real a;
    a = 6.283185307179586 * real'(p) / 4294967296.0;
    return int'(127.0 * $sin(a));
  endfunction

  task automatic cmp(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_tol(input string nm, input longint act, input longint exp, input longint tol);
    longint diff;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    n_cmp++;
    if (diff > tol) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d +-%0d", nm, act, exp, tol);
    end
  endtask

  // Reference behaviour, advanced once per clock edge with the sample that edge captures.
  task automatic m_step(input bit e, input bit v, input int d);
    bit r;
    res_t rec;
    if (!e) begin
      m_state = 0; m_armed = 1'b0; m_busy = 0; m_s = 0; m_per = 0;
      return;
    end
    r = v && m_armed && (d >= 0);
    if (v && d <= -HYST) m_armed = 1'b1;
    else if (r) m_armed = 1'b0;
    case (m_state)
      0: if (r) begin
        m_state = 1; m_s = 0; m_per = 0; m_peak = d;
      end
      1: if (v) begin
        m_s++;
        if (d > m_peak) m_peak = d;
        if (r && m_per == NPER - 1) begin
          m_state = 2; m_busy = DIV_LAT;
        end else begin
          if (r) m_per++;
          if (m_s == TMO) begin
            tq.push_back(cyc); m_state = 0;
          end
        end
      end
      default: begin
        m_busy--;
        if (m_busy == 0) begin
          rec.cyc = cyc; rec.s = m_s; rec.fw = NUM / longint'(m_s); rec.pk = m_peak;
          mq.push_back(rec);
          m_state = 0;
        end
      end
    endcase
  endtask

  task automatic check();
    res_t r;
    int   t;
    if (meas_valid) begin
      meas_cnt++;
      if (mq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL meas_unexpected: actual pulse at cycle %0d required none", cyc);
      end else begin
        r = mq.pop_front();
        cmp("meas_cycle", longint'(cyc), longint'(r.cyc));
        cmp("sample_cnt", longint'(sample_cnt), longint'(r.s));
        cmp("fword_est", longint'(fword_est), r.fw);
        cmp("amp_peak", longint'(amp_peak), longint'(r.pk));
        last_s = r.s; last_fw = r.fw; last_pk = r.pk;
        if (cur_on) begin
          cmp_tol("tbl_sample_cnt", longint'(sample_cnt), cur.es, longint'(cur.stol));
          cmp_tol("tbl_fword_est", longint'(fword_est), cur.efw, cur.fwtol);
          cmp("tbl_amp_peak", longint'(amp_peak), longint'(cur.pk));
        end
      end
    end else if (mq.size() > 0 && mq[0].cyc <= cyc) begin
      r = mq.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL meas_missing: actual none required pulse at cycle %0d", r.cyc);
    end
    if (timeout) begin
      tmo_cnt++;
      if (tq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL tmo_unexpected: actual pulse at cycle %0d required none", cyc);
      end else begin
        t = tq.pop_front();
        cmp("tmo_cycle", longint'(cyc), longint'(t));
        cmp("tmo_hold_fword", longint'(fword_est), last_fw);
        cmp("tmo_hold_cnt", longint'(sample_cnt), longint'(last_s));
        cmp("tmo_hold_peak", longint'(amp_peak), longint'(last_pk));
      end
    end else if (tq.size() > 0 && tq[0] <= cyc) begin
      t = tq.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL tmo_missing: actual none required pulse at cycle %0d", t);
    end
  endtask

  task automatic step(input bit e, input bit v, input int d);
    en = e;
    din_valid = v;
    din = 8'(d);
    @(posedge clk);
    cyc++;
    m_step(e, v, d);
    @(negedge clk);
    check();
  endtask

  task automatic en_low(input int n);
    repeat (n) step(1'b0, 1'b0, 0);
  endtask

  task automatic run_sine(input logic [31:0] fw, input int noise, input int duty,
                          input int max_cyc, input int meas_target, input bit stop_busy);
    int k;
    int d;
    bit v;
    bit done;
    k = 0;
    done = 1'b0;
    while (k < max_cyc && !done) begin
      v = ((k % duty) == 0);
      d = 0;
      if (v) begin
        d = sine_of(ph);
        if (noise > 0 && d > -16 && d < 16)
          d = d + int'($urandom_range(2 * noise)) - noise;
        ph = ph + fw;
      end
      step(1'b1, v, d);
      k++;
      done = (meas_target > 0 && meas_cnt >= meas_target) || (stop_busy && m_state == 2);
    end
    if (meas_target > 0 || stop_busy) begin
      n_cmp++;
      if (!done) begin
        n_bad++;
        $display("FAIL run_budget: actual no event in %0d cycles required event", k);
      end
    end
  endtask

  initial begin
    #(20 * 200000);
    $display("FAIL watchdog: actual still running required finish");
    $fatal(1);
  end

  initial begin
    int m0;
    int t0;
    vt[0] = mk(32'h0400_0000, 0, 1, 3, 0, 1024, 64'h0400_0000, 0, 127);
    vt[1] = mk(32'h0123_4567, 0, 1, 2, 2, (longint'(NPER) << 32) / 64'h0123_4567,
               64'h0123_4567, 64'h0123_4567 / 64, 127);
    vt[2] = mk(32'h0400_0000, 5, 1, 3, 1, 1024, 64'h0400_0000, 70000, 127);
    vt[3] = mk(32'h0400_0000, 0, 2, 2, 0, 1024, 64'h0400_0000, 0, 127);

    en = 1'b0; din_valid = 1'b0; din = '0; rst_n = 1'b1;
    #5 rst_n = 1'b0;
    #1;
    cmp("rst_fword", longint'(fword_est), 0);
    cmp("rst_cnt", longint'(sample_cnt), 0);
    cmp("rst_peak", longint'(amp_peak), 0);
    cmp("rst_meas_valid", longint'(meas_valid), 0);
    cmp("rst_timeout", longint'(timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      cur = vt[i];
      cur_on = 1'b1;
      ph = '0;
      run_sine(vt[i].fw, vt[i].noise, vt[i].duty, 30000, meas_cnt + vt[i].nres, 1'b0);
      en_low(3);
    end

    // Timeout: one arm/rise, then a flat stream.
    cur_on = 1'b0;
    t0 = tmo_cnt;
    m0 = meas_cnt;
    step(1'b1, 1'b1, -20);
    step(1'b1, 1'b1, 0);
    repeat (TMO + 10) step(1'b1, 1'b1, 0);
    cmp("tmo_pulse_count", longint'(tmo_cnt - t0), 1);
    cmp("tmo_no_meas", longint'(meas_cnt - m0), 0);
    en_low(3);

    // Enable dropped mid-COUNT.
    cur = vt[0];
    cur_on = 1'b1;
    ph = '0;
    m0 = meas_cnt;
    run_sine(32'h0400_0000, 0, 1, 600, 0, 1'b0);
    en_low(3);
    cmp("count_abort_no_meas", longint'(meas_cnt - m0), 0);
    run_sine(32'h0400_0000, 0, 1, 4000, meas_cnt + 1, 1'b0);
    en_low(3);

    // Enable dropped mid-DIV.
    ph = '0;
    m0 = meas_cnt;
    run_sine(32'h0400_0000, 0, 1, 4000, 0, 1'b1);
    run_sine(32'h0400_0000, 0, 1, 5, 0, 1'b0);
    en_low(3);
    run_sine(32'h0400_0000, 0, 1, 60, 0, 1'b0);
    cmp("div_abort_no_meas", longint'(meas_cnt - m0), 0);
    run_sine(32'h0400_0000, 0, 1, 4000, meas_cnt + 1, 1'b0);
    en_low(3);

    // Reset pulse mid-DIV clears held outputs at once.
    ph = '0;
    run_sine(32'h0400_0000, 0, 1, 4000, 0, 1'b1);
    run_sine(32'h0400_0000, 0, 1, 10, 0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    cmp("midrst_fword", longint'(fword_est), 0);
    cmp("midrst_cnt", longint'(sample_cnt), 0);
    cmp("midrst_peak", longint'(amp_peak), 0);
    cmp("midrst_meas_valid", longint'(meas_valid), 0);
    cmp("midrst_timeout", longint'(timeout), 0);
    mq.delete();
    tq.delete();
    m_state = 0; m_armed = 1'b0; m_busy = 0; m_s = 0; m_per = 0;
    last_s = 0; last_fw = 0; last_pk = 0;
    @(negedge clk);
    rst_n = 1'b1;
    ph = '0;
    run_sine(32'h0400_0000, 0, 1, 4000, meas_cnt + 1, 1'b0);

    cmp("pending_meas", longint'(mq.size()), 0);
    cmp("pending_tmo", longint'(tq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
